// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM tpumac array: clear, feed, drain, shift-out readout, done.
// Latency: start sampled in cycle 0 -> done pulse in cycle 4*DIM+1; abort returns to IDLE in 1 cycle.
module systolic_ctrl #(
    parameter int DIM = 8,
    parameter int AW  = $clog2(DIM),
    parameter int CW  = $clog2(3*DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic          feed_valid,
    output logic          mac_en,
    output logic          mac_wren,
    output logic          c_sel,
    output logic          out_valid,
    output logic [AW-1:0] out_row
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READOUT, S_DONE
    } state_t;

    localparam logic [CW-1:0] FEED_LAST  = CW'(DIM - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2*DIM - 2);
    localparam logic [CW-1:0] READ_LAST  = CW'(DIM - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            feed_valid_q;
    logic            abort_hit;

    assign abort_hit = abort && (state_q != S_IDLE);

    // The phase counter restarts on every state entry, so no state can inherit a stale count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_READOUT;
                    cnt_d   = '0;
                end
            end
            S_READOUT: begin
                if (cnt_q == READ_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            feed_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            feed_valid_q <= mem_rd && !abort_hit;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mem_rd     = (state_q == S_FEED);
    assign mem_addr   = mem_rd ? cnt_q[AW-1:0] : '0;
    assign feed_valid = feed_valid_q;
    // Drain keeps the MACs running until the last skewed operand reaches the far corner.
    assign mac_en     = feed_valid_q || (state_q == S_DRAIN);
    assign mac_wren   = (state_q == S_CLEAR) || (state_q == S_READOUT);
    assign c_sel      = (state_q == S_READOUT);
    assign out_valid  = (state_q == S_READOUT);
    assign out_row    = out_valid ? cnt_q[AW-1:0] : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: phase-based timeline model for DIM=4, plus a 2x2 array model
// driven by a DIM=2 instance whose readout is compared with a plain matrix product.
module tb_systolic_ctrl;

    localparam int D   = 4;
    localparam int AW  = $clog2(D);
    localparam int D2  = 2;
    localparam int AW2 = $clog2(D2);
    localparam int OW  = 8 + 2*AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort;
    logic busy, done, mem_rd, feed_valid, mac_en, mac_wren, c_sel, out_valid;
    logic [AW-1:0] mem_addr, out_row;

    logic start2, abort2;
    logic busy2, done2, mem_rd2, feed_valid2, mac_en2, mac_wren2, c_sel2, out_valid2;
    logic [AW2-1:0] mem_addr2, out_row2;

    systolic_ctrl #(.DIM(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .feed_valid(feed_valid), .mac_en(mac_en), .mac_wren(mac_wren), .c_sel(c_sel),
        .out_valid(out_valid), .out_row(out_row)
    );

    systolic_ctrl #(.DIM(D2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .feed_valid(feed_valid2), .mac_en(mac_en2), .mac_wren(mac_wren2), .c_sel(c_sel2),
        .out_valid(out_valid2), .out_row(out_row2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: one run is "active" from its CLEAR cycle t0 through t0+4*D (DONE).
    bit m_active = 1'b0;
    int m_t0     = 0;
    int cyc      = 0;

    function automatic logic [OW-1:0] obs_vec();
        return {busy, done, mem_rd, mem_addr, feed_valid, mac_en, mac_wren, c_sel, out_valid, out_row};
    endfunction

    function automatic logic [OW-1:0] model_vec(input bit act, input int p);
        logic b, dn, rd, fv, me, mw, cs, ov;
        logic [AW-1:0] ad, orow;
        b = 0; dn = 0; rd = 0; fv = 0; me = 0; mw = 0; cs = 0; ov = 0; ad = '0; orow = '0;
        if (act) begin
            b    = 1'b1;
            dn   = (p == 4*D);
            rd   = (p >= 1) && (p <= D);
            ad   = rd ? AW'(p - 1) : '0;
            fv   = (p >= 2) && (p <= D + 1);
            me   = (p >= 2) && (p <= 3*D - 1);
            ov   = (p >= 3*D) && (p < 4*D);
            cs   = ov;
            mw   = (p == 0) || ov;
            orow = ov ? AW'(p - 3*D) : '0;
        end
        return {b, dn, rd, ad, fv, me, mw, cs, ov, orow};
    endfunction

    // Applies inputs for the current cycle, advances one clock, returns observed/expected.
    task automatic tick(input logic st, input logic ab, output logic [OW-1:0] o, output logic [OW-1:0] e);
        start = st;
        abort = ab;
        if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_t0     = cyc + 1;
            end
        end else if (ab) begin
            m_active = 1'b0;
        end else if (cyc - m_t0 == 4*D) begin
            m_active = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        o = obs_vec();
        e = model_vec(m_active, cyc - m_t0);
    endtask

    // ---------------- 2x2 tpumac array model ----------------
    logic signed [15:0] ma [2][2];
    logic signed [15:0] mb [2][2];
    logic signed [15:0] am [2][2];
    logic signed [15:0] bm [2][2];
    logic signed [15:0] cm [2][2];
    logic signed [15:0] na [2][2];
    logic signed [15:0] nb [2][2];
    logic signed [15:0] nc [2][2];
    bit                 fvh [256];
    logic [AW2-1:0]     kh  [256];
    logic [AW2-1:0]     rd_k2;
    logic [7:0]         tc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    am[i][j] = '0; bm[i][j] = '0; cm[i][j] = '0;
                end
            for (int t = 0; t < 256; t++) begin
                fvh[t] = 1'b0; kh[t] = '0;
            end
            rd_k2 = '0;
            tc    = '0;
        end else begin
            logic signed [15:0] ain, bin, cin;
            logic [7:0] idx;
            fvh[tc] = feed_valid2;
            kh[tc]  = rd_k2;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (j == 0) begin
                        idx = tc - 8'(i);
                        ain = fvh[idx] ? ma[i][kh[idx]] : 16'sd0;
                    end else ain = am[i][j-1];
                    if (i == 0) begin
                        idx = tc - 8'(j);
                        bin = fvh[idx] ? mb[kh[idx]][j] : 16'sd0;
                    end else bin = bm[i-1][j];
                    cin = (c_sel2 && i < 1) ? cm[i+1][j] : 16'sd0;
                    na[i][j] = mac_en2 ? ain : am[i][j];
                    nb[i][j] = mac_en2 ? bin : bm[i][j];
                    if (mac_wren2)   nc[i][j] = cin;
                    else if (mac_en2) nc[i][j] = cm[i][j] + ain * bin;
                    else             nc[i][j] = cm[i][j];
                end
            end
            am = na; bm = nb; cm = nc;
            if (mem_rd2) rd_k2 = mem_addr2;
            tc = tc + 8'd1;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [OW-1:0] o, e;
        rst_n = 1'b1; start = 0; abort = 0; start2 = 0; abort2 = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs_vec() !== '0) begin n_fail++; $display("FAIL reset_init: got %b want 0", obs_vec()); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc = 0; m_active = 1'b0;
        tick(1'b1, 1'b0, o, e);
        tick(1'b0, 1'b0, o, e);
        tick(1'b0, 1'b0, o, e);
        n_tests++;
        if (o !== e || mem_rd !== 1'b1) begin n_fail++; $display("FAIL reset_prefeed: got %b want %b", o, e); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== '0) begin n_fail++; $display("FAIL reset_async: got %b want 0", obs_vec()); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc = 0; m_active = 1'b0;
        for (int r = 0; r < 6; r++) begin
            tick(1'b0, 1'b0, o, e);
            n_tests++;
            if (o !== e || o !== '0) begin n_fail++; $display("FAIL reset_idle r%0d: got %b want %b", r, o, e); end
        end
    endtask

    task automatic test_nominal();
        logic [OW-1:0] o, e;
        int base, rel, me_cnt, me_first, done_rel;
        me_cnt = 0; me_first = -1; done_rel = -1;
        base = cyc;
        tick(1'b1, 1'b0, o, e);
        for (int r = 1; r <= 18; r++) begin
            rel = cyc - base;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL nominal cyc%0d: got %b want %b", rel, o, e); end
            if (mac_en) begin
                me_cnt++;
                if (me_first < 0) me_first = rel;
            end
            if (done) done_rel = rel;
            if (r < 18) tick(1'b0, 1'b0, o, e);
        end
        n_tests++;
        if (me_cnt !== 3*D-2 || me_first !== 3) begin
            n_fail++; $display("FAIL nominal_mac_en: got %0d cycles from %0d want %0d from 3", me_cnt, me_first, 3*D-2);
        end
        n_tests++;
        if (done_rel !== 4*D+1) begin n_fail++; $display("FAIL nominal_done: got cyc%0d want cyc%0d", done_rel, 4*D+1); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_ignored_start();
        logic [OW-1:0] o, e;
        int base, dcnt;
        dcnt = 0;
        base = cyc;
        tick(1'b1, 1'b0, o, e);
        for (int r = 1; r <= 19; r++) begin
            tick((r == 5) || (r == 17), 1'b0, o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL ignored_start cyc%0d: got %b want %b", cyc - base, o, e); end
            if (done) dcnt++;
            if (cyc - base >= 18) begin
                n_tests++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_rerun cyc%0d: got busy %b want 0", cyc - base, busy); end
            end
        end
        n_tests++;
        if (dcnt !== 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", dcnt); end
    endtask

    task automatic test_abort();
        logic [OW-1:0] o, e;
        int base, dcnt;
        dcnt = 0;
        base = cyc;
        tick(1'b1, 1'b0, o, e);
        for (int r = 1; r <= 20; r++) begin
            tick(1'b0, r == 8, o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL abort cyc%0d: got %b want %b", cyc - base, o, e); end
            if (cyc - base == 9) begin
                n_tests++;
                if (o !== '0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", o); end
            end
            if (done) dcnt++;
        end
        n_tests++;
        if (dcnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", dcnt); end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] o, e;
        int base, d1, d2, c2;
        d1 = -1; d2 = -1; c2 = -1;
        base = cyc;
        tick(1'b1, 1'b0, o, e);
        for (int r = 1; r <= 36; r++) begin
            tick(r == 18, 1'b0, o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b cyc%0d: got %b want %b", cyc - base, o, e); end
            if (done) begin
                if (d1 < 0) d1 = cyc - base; else d2 = cyc - base;
            end
            if (cyc - base > 18 && c2 < 0 && mac_wren && !c_sel) c2 = cyc - base;
        end
        n_tests++;
        if (d1 !== 17 || d2 !== 35 || c2 !== 19) begin
            n_fail++; $display("FAIL b2b_timing: got done %0d/%0d clear %0d want 17/35 19", d1, d2, c2);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] o, e;
        logic st, ab;
        for (int r = 0; r < 800; r++) begin
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 39) == 0);
            tick(st, ab, o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL random r%0d: got %b want %b", r, o, e); end
        end
        tick(1'b0, 1'b1, o, e);
    endtask

    task automatic test_integration(input bit rnd);
        logic signed [15:0] cexp [2][2];
        int rows;
        bit dn;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (rnd) begin
                    ma[i][j] = 16'($signed($urandom_range(0, 15)) - 8);
                    mb[i][j] = 16'($signed($urandom_range(0, 15)) - 8);
                end else begin
                    ma[i][j] = 16'(2*i + j + 1);
                    mb[i][j] = 16'(2*i + j + 5);
                end
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                cexp[i][j] = 16'(ma[i][0]*mb[0][j] + ma[i][1]*mb[1][j]);
        rows = 0; dn = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int c = 0; c < 20 && !dn; c++) begin
            if (out_valid2) begin
                for (int j = 0; j < 2; j++) begin
                    n_tests++;
                    if (cm[0][j] !== cexp[out_row2][j]) begin
                        n_fail++; $display("FAIL integ row%0d col%0d: got %0d want %0d", out_row2, j, cm[0][j], cexp[out_row2][j]);
                    end
                end
                rows++;
            end
            if (done2) dn = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_tests++;
        if (rows !== 2 || !dn) begin n_fail++; $display("FAIL integ_rows: got %0d rows done %b want 2 rows done 1", rows, dn); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        test_random();
        test_integration(1'b0);
        test_integration(1'b1);
        test_integration(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
